// File: rtl/sad_pkg.sv
// Shared definitions for the SAD pipeline: window geometry, pixel/vector widths,
// fetcher FSM states and the pixel address helper.
package sad_pkg;
   localparam int WIN_DIM = 4;
   localparam int PIX_W   = 32;
   localparam int VEC_W   = WIN_DIM * PIX_W;
   localparam int COORD_W = 16;
   localparam int ADDR_W  = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CAPTURE,
      ST_OUT,
      ST_DONE
   } fetch_state_e;

   typedef logic [COORD_W-1:0] coord_t;

   // Byte address of pixel (x+col) on the row starting at row_base, modulo 2^32.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] row_base,
                                                  input coord_t            x,
                                                  input logic [1:0]        col);
      logic [COORD_W:0] px;
      px = {1'b0, x} + {15'b0, col};
      return row_base + {13'b0, px, 2'b00};
   endfunction
endpackage

// File: rtl/sad_addr_gen.sv
// Window position counters (x, y, row) and row-base accumulator for the fetcher.
// SAD_FETCH_ZERO_PAD_EN widens the scan range and reports which pixels fall off the frame.
module sad_addr_gen
   import sad_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init,
   input  logic              adv,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       frame_w,
   input  logic [15:0]       frame_h,
   output coord_t            x,
   output coord_t            y,
   output logic [1:0]        row,
   output logic [ADDR_W-1:0] row_base,
   output coord_t            nxt_x,
   output logic [ADDR_W-1:0] nxt_row_base,
   output logic [3:0]        pad_cur,
   output logic              pad_nxt,
   output logic              last
);
   coord_t            x_q, x_d, y_q, y_d, x_max_q, x_max_d, y_max_q, y_max_d;
   logic [1:0]        row_q, row_d;
   logic [ADDR_W-1:0] win_base_q, win_base_d, row_base_q, row_base_d, stride_q, stride_d;

   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      row_d      = row_q;
      win_base_d = win_base_q;
      row_base_d = row_base_q;
      stride_d   = stride_q;
      x_max_d    = x_max_q;
      y_max_d    = y_max_q;
      if (init) begin
         x_d        = '0;
         y_d        = '0;
         row_d      = '0;
         win_base_d = base_addr;
         row_base_d = base_addr;
         stride_d   = {14'b0, frame_w, 2'b00};
`ifdef SAD_FETCH_ZERO_PAD_EN
         x_max_d    = frame_w - 16'd1;
         y_max_d    = frame_h - 16'd1;
`else
         x_max_d    = frame_w - 16'd4;
         y_max_d    = frame_h - 16'd4;
`endif
      end else if (adv) begin
         if (row_q != 2'd3) begin
            row_d      = row_q + 2'd1;
            row_base_d = row_base_q + stride_q;
         end else begin
            row_d = '0;
            if (x_q != x_max_q) begin
               x_d        = x_q + 16'd1;
               row_base_d = win_base_q;
            end else begin
               x_d        = '0;
               y_d        = y_q + 16'd1;
               win_base_d = win_base_q + stride_q;
               row_base_d = win_base_q + stride_q;
            end
         end
      end
   end

`ifdef SAD_FETCH_ZERO_PAD_EN
   coord_t fw_q, fw_d, fh_q, fh_d;

   assign fw_d = init ? frame_w : fw_q;
   assign fh_d = init ? frame_h : fh_q;

   // Column 0 of the next window never lies right of the frame, only the row can be off.
   always_comb begin
      pad_cur = '0;
      for (int c = 0; c < 4; c++) begin
         pad_cur[c] = (({1'b0, x_q} + 17'(c)) >= {1'b0, fw_q}) ||
                      (({1'b0, y_q} + {15'b0, row_q}) >= {1'b0, fh_q});
      end
      pad_nxt = ({1'b0, y_d} + {15'b0, row_d}) >= {1'b0, fh_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fw_q <= '0;
         fh_q <= '0;
      end else begin
         fw_q <= fw_d;
         fh_q <= fh_d;
      end
   end
`else
   assign pad_cur = '0;
   assign pad_nxt = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q        <= '0;
         y_q        <= '0;
         row_q      <= '0;
         win_base_q <= '0;
         row_base_q <= '0;
         stride_q   <= '0;
         x_max_q    <= '0;
         y_max_q    <= '0;
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         row_q      <= row_d;
         win_base_q <= win_base_d;
         row_base_q <= row_base_d;
         stride_q   <= stride_d;
         x_max_q    <= x_max_d;
         y_max_q    <= y_max_d;
      end
   end

   assign x            = x_q;
   assign y            = y_q;
   assign row          = row_q;
   assign row_base     = row_base_q;
   assign nxt_x        = x_d;
   assign nxt_row_base = row_base_d;
   assign last         = (row_q == 2'd3) && (x_q == x_max_q) && (y_q == y_max_q);
endmodule

// File: rtl/sad_vector_fetcher.sv
// Scans a frame in 4x4 windows and emits one 4-pixel row vector per handshake.
// SAD_FETCH_ZERO_PAD_EN scans every pixel origin and zero-fills pixels outside the frame.
//   state   | meaning
//   IDLE    | waiting for start
//   READ    | issuing the four column reads of one window row
//   CAPTURE | last read data returning
//   OUT     | vec_valid high, waiting for vec_ready
//   DONE    | one-cycle done pulse
module sad_vector_fetcher
   import sad_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [15:0]        frame_w,
   input  logic [15:0]        frame_h,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [PIX_W-1:0]   mem_rdata,
   output logic [VEC_W-1:0]   vec_data,
   output logic [COORD_W-1:0] vec_x,
   output logic [COORD_W-1:0] vec_y,
   output logic [1:0]         vec_row,
   output logic               vec_last,
   output logic               vec_valid,
   input  logic               vec_ready,
   output logic               busy,
   output logic               done
);
   fetch_state_e      state_q, state_d;
   logic [1:0]        col_q, col_d, iss_col_q, iss_col_d, pend_col_q, pend_col_d;
   logic              mem_rd_en_q, mem_rd_en_d, pend_q, pend_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [VEC_W-1:0]  vec_data_q, vec_data_d;
   logic              vec_valid_q, vec_valid_d, busy_q, busy_d, done_q, done_d;

   logic              ag_init, ag_adv, ag_last, pad_nxt, frame_small;
   logic              iss_go, iss_nxt, iss_pad;
   logic [1:0]        iss_col;
   coord_t            ag_x, ag_y, nxt_x, iss_x;
   logic [1:0]        ag_row;
   logic [3:0]        pad_cur;
   logic [ADDR_W-1:0] row_base, nxt_row_base, iss_rb;

`ifdef SAD_FETCH_ZERO_PAD_EN
   assign frame_small = (frame_w == 16'd0) || (frame_h == 16'd0);
`else
   assign frame_small = (frame_w < 16'd4) || (frame_h < 16'd4);
`endif

   sad_addr_gen u_addr_gen (
      .clk          (clk),
      .rst_n        (rst_n),
      .init         (ag_init),
      .adv          (ag_adv),
      .base_addr    (base_addr),
      .frame_w      (frame_w),
      .frame_h      (frame_h),
      .x            (ag_x),
      .y            (ag_y),
      .row          (ag_row),
      .row_base     (row_base),
      .nxt_x        (nxt_x),
      .nxt_row_base (nxt_row_base),
      .pad_cur      (pad_cur),
      .pad_nxt      (pad_nxt),
      .last         (ag_last)
   );

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      iss_col_d   = iss_col_q;
      mem_rd_en_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      pend_d      = mem_rd_en_q;
      pend_col_d  = iss_col_q;
      vec_data_d  = vec_data_q;
      vec_valid_d = vec_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ag_init     = 1'b0;
      ag_adv      = 1'b0;
      iss_go      = 1'b0;
      iss_nxt     = 1'b0;
      iss_col     = col_q;
      iss_x       = ag_x;
      iss_rb      = row_base;
      iss_pad     = 1'b0;

      if (pend_q) vec_data_d[pend_col_q*PIX_W +: PIX_W] = mem_rdata;

      // Column 0 of a new row is issued on the same edge the counters move,
      // so it uses the counters' next values.
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (frame_small) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  ag_init = 1'b1;
                  iss_go  = 1'b1;
                  iss_nxt = 1'b1;
                  iss_col = 2'd0;
                  col_d   = 2'd1;
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (col_q != 2'd0) begin
               iss_go = 1'b1;
               col_d  = col_q + 2'd1;
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            vec_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (vec_ready) begin
               vec_valid_d = 1'b0;
               ag_adv      = 1'b1;
               if (ag_last) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  iss_go  = 1'b1;
                  iss_nxt = 1'b1;
                  iss_col = 2'd0;
                  col_d   = 2'd1;
                  state_d = ST_READ;
               end
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (iss_go) begin
         iss_x       = iss_nxt ? nxt_x : ag_x;
         iss_rb      = iss_nxt ? nxt_row_base : row_base;
         iss_pad     = iss_nxt ? pad_nxt : pad_cur[iss_col];
         mem_addr_d  = pix_addr(iss_rb, iss_x, iss_col);
         mem_rd_en_d = !iss_pad;
         iss_col_d   = iss_col;
         if (iss_pad) vec_data_d[iss_col*PIX_W +: PIX_W] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         iss_col_q   <= '0;
         pend_col_q  <= '0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
         pend_q      <= 1'b0;
         vec_data_q  <= '0;
         vec_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         iss_col_q   <= iss_col_d;
         pend_col_q  <= pend_col_d;
         mem_rd_en_q <= mem_rd_en_d;
         mem_addr_q  <= mem_addr_d;
         pend_q      <= pend_d;
         vec_data_q  <= vec_data_d;
         vec_valid_q <= vec_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_rd_en = mem_rd_en_q;
   assign mem_addr  = mem_addr_q;
   assign vec_data  = vec_data_q;
   assign vec_x     = ag_x;
   assign vec_y     = ag_y;
   assign vec_row   = ag_row;
   assign vec_last  = (ag_row == 2'd3);
   assign vec_valid = vec_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule
